// File: rtl/ram_sync_clr_if.sv
// Access bus between the CPU datapath and ram_sync_clr.
// The master drives requests; the RAM returns read data, valid strobe and ready.
interface ram_sync_clr_if #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 256
);
    localparam int ADDR_WIDTH = $clog2(DEPTH);
    localparam int NBYTES     = DATA_WIDTH / 8;

    logic                  write_enable;
    logic [NBYTES-1:0]     byte_en;
    logic                  ram_read;
    logic [ADDR_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0] write_data;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  data_valid;
    logic                  ready;

    modport master (
        output write_enable, byte_en, ram_read, address, write_data,
        input  data_out, data_valid, ready
    );

    modport slave (
        input  write_enable, byte_en, ram_read, address, write_data,
        output data_out, data_valid, ready
    );
endinterface

// File: rtl/ram_sync_clr.sv
// Single-port synchronous RAM with byte enables, registered reads with a valid strobe,
// and a clear engine that zero-fills the array after every reset before raising ready.
module ram_sync_clr #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 256
) (
    input  logic          clk,
    input  logic          reset,
    ram_sync_clr_if.slave bus
);
    localparam int ADDR_WIDTH = $clog2(DEPTH);
    localparam int NBYTES     = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic {CLEAR, IDLE} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  data_valid_q, data_valid_d;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  in_range;
    logic [DATA_WIDTH-1:0] old_word;
    logic [DATA_WIDTH-1:0] merged_word;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;

    // Addresses past DEPTH exist only when DEPTH is not a power of two.
    assign in_range = ({1'b0, bus.address} < DEPTH_EXT);
    assign old_word = in_range ? mem[bus.address] : '0;

    always_comb begin
        merged_word = old_word;
        if (bus.write_enable) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (bus.byte_en[i]) begin
                    merged_word[8*i +: 8] = bus.write_data[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        clr_addr_d   = clr_addr_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        mem_we       = 1'b0;
        mem_waddr    = bus.address;
        mem_wdata    = merged_word;
        unique case (state_q)
            CLEAR: begin
                mem_we     = 1'b1;
                mem_waddr  = clr_addr_q;
                mem_wdata  = '0;
                clr_addr_d = clr_addr_q + ADDR_WIDTH'(1);
                if (clr_addr_q == LAST_ADDR) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                mem_we = bus.write_enable && in_range && (|bus.byte_en);
                // Write-first: a same-edge read returns the merged word.
                if (bus.ram_read) begin
                    data_out_d   = in_range ? merged_word : '0;
                    data_valid_d = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= CLEAR;
            clr_addr_q   <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_addr_q   <= clr_addr_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
        end
    end

    // The array has no reset; the reset edge itself leaves contents alone.
    always_ff @(posedge clk) begin
        if (!reset && mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign bus.ready      = (state_q == IDLE);
    assign bus.data_out   = data_out_q;
    assign bus.data_valid = data_valid_q;
endmodule

// File: tb/tb_ram_sync_clr.sv
// Randomised bench for ram_sync_clr: a 256x16 instance and a 100x32 instance,
// each compared every cycle against an array model of the RAM.
module tb_ram_sync_clr;
    logic clk = 1'b0;
    logic resetA;
    logic resetB;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    ram_sync_clr_if #(.DATA_WIDTH(16), .DEPTH(256)) ifA ();
    ram_sync_clr_if #(.DATA_WIDTH(32), .DEPTH(100)) ifB ();

    ram_sync_clr #(.DATA_WIDTH(16), .DEPTH(256)) dutA (.clk(clk), .reset(resetA), .bus(ifA.slave));
    ram_sync_clr #(.DATA_WIDTH(32), .DEPTH(100)) dutB (.clk(clk), .reset(resetB), .bus(ifB.slave));

    // Reference state: array contents, edges of clearing left, expected outputs.
    logic [15:0] memA [256];
    int          clearLeftA = 256;
    logic [15:0] expOutA = '0;
    logic        expValidA = 1'b0;

    logic [31:0] memB [100];
    int          clearLeftB = 100;
    logic [31:0] expOutB = '0;
    logic        expValidB = 1'b0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulusA(input logic rst, input logic we, input logic [1:0] be,
                                  input logic rd, input logic [7:0] addr, input logic [15:0] wd);
        resetA           = rst;
        ifA.write_enable = we;
        ifA.byte_en      = be;
        ifA.ram_read     = rd;
        ifA.address      = addr;
        ifA.write_data   = wd;
        @(posedge clk);
        if (rst) begin
            clearLeftA = 256;
            expOutA    = '0;
            expValidA  = 1'b0;
        end else if (clearLeftA > 0) begin
            clearLeftA--;
            expValidA = 1'b0;
            if (clearLeftA == 0) begin
                foreach (memA[i]) memA[i] = '0;
            end
        end else begin
            if (we) begin
                for (int b = 0; b < 2; b++) begin
                    if (be[b]) memA[addr][8*b +: 8] = wd[8*b +: 8];
                end
            end
            expValidA = rd;
            if (rd) expOutA = memA[addr];
        end
        #1;
        checkOutput("A.ready", 32'(ifA.ready), 32'(clearLeftA == 0));
        checkOutput("A.valid", 32'(ifA.data_valid), 32'(expValidA));
        checkOutput("A.data", 32'(ifA.data_out), 32'(expOutA));
    endtask

    task automatic applyStimulusB(input logic rst, input logic we, input logic [3:0] be,
                                  input logic rd, input logic [6:0] addr, input logic [31:0] wd);
        resetB           = rst;
        ifB.write_enable = we;
        ifB.byte_en      = be;
        ifB.ram_read     = rd;
        ifB.address      = addr;
        ifB.write_data   = wd;
        @(posedge clk);
        if (rst) begin
            clearLeftB = 100;
            expOutB    = '0;
            expValidB  = 1'b0;
        end else if (clearLeftB > 0) begin
            clearLeftB--;
            expValidB = 1'b0;
            if (clearLeftB == 0) begin
                foreach (memB[i]) memB[i] = '0;
            end
        end else begin
            if (we && addr < 100) begin
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) memB[addr][8*b +: 8] = wd[8*b +: 8];
                end
            end
            expValidB = rd;
            if (rd) expOutB = (addr < 100) ? memB[addr] : 32'h0;
        end
        #1;
        checkOutput("B.ready", 32'(ifB.ready), 32'(clearLeftB == 0));
        checkOutput("B.valid", 32'(ifB.data_valid), 32'(expValidB));
        checkOutput("B.data", ifB.data_out, expOutB);
    endtask

    task automatic randomA(input int cycles, input int addrMax);
        for (int n = 0; n < cycles; n++) begin
            applyStimulusA(1'b0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                           1'($urandom_range(0, 1)), 8'($urandom_range(0, addrMax)),
                           16'($urandom));
        end
    endtask

    task automatic randomB(input int cycles);
        for (int n = 0; n < cycles; n++) begin
            applyStimulusB(1'b0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                           1'($urandom_range(0, 1)), 7'($urandom_range(0, 127)),
                           $urandom);
        end
    endtask

    initial begin
        resetB           = 1'b1;
        ifB.write_enable = 1'b0;
        ifB.byte_en      = '0;
        ifB.ram_read     = 1'b0;
        ifB.address      = '0;
        ifB.write_data   = '0;

        // 256x16 instance: reset, clear with ignored accesses, full read-back.
        applyStimulusA(1'b1, 1'b0, 2'b00, 1'b0, 8'h00, 16'h0);
        applyStimulusA(1'b1, 1'b0, 2'b00, 1'b0, 8'h00, 16'h0);
        checkOutput("A.resetData", 32'(ifA.data_out), 32'h0);
        randomA(256, 255);
        checkOutput("A.readyAfterClear", 32'(ifA.ready), 32'h1);
        for (int a = 0; a < 256; a++) applyStimulusA(1'b0, 1'b0, 2'b00, 1'b1, 8'(a), 16'h0);

        applyStimulusA(1'b0, 1'b1, 2'b11, 1'b0, 8'h00, 16'h4002);
        applyStimulusA(1'b0, 1'b0, 2'b00, 1'b1, 8'h00, 16'h0);
        checkOutput("A.basicRead", 32'(ifA.data_out), 32'h4002);
        applyStimulusA(1'b0, 1'b0, 2'b00, 1'b1, 8'h01, 16'h0);
        checkOutput("A.neighbour", 32'(ifA.data_out), 32'h0);

        applyStimulusA(1'b0, 1'b1, 2'b11, 1'b0, 8'h10, 16'hABCD);
        applyStimulusA(1'b0, 1'b1, 2'b01, 1'b0, 8'h10, 16'h1234);
        applyStimulusA(1'b0, 1'b0, 2'b00, 1'b1, 8'h10, 16'h0);
        checkOutput("A.byteLow", 32'(ifA.data_out), 32'hAB34);
        applyStimulusA(1'b0, 1'b1, 2'b10, 1'b0, 8'h10, 16'h5678);
        applyStimulusA(1'b0, 1'b0, 2'b00, 1'b1, 8'h10, 16'h0);
        checkOutput("A.byteHigh", 32'(ifA.data_out), 32'h5634);

        applyStimulusA(1'b0, 1'b1, 2'b11, 1'b0, 8'h20, 16'h1111);
        applyStimulusA(1'b0, 1'b1, 2'b11, 1'b1, 8'h20, 16'h2222);
        checkOutput("A.writeFirst", 32'(ifA.data_out), 32'h2222);
        applyStimulusA(1'b0, 1'b0, 2'b00, 1'b0, 8'h20, 16'h0);
        checkOutput("A.holdValid", 32'(ifA.data_valid), 32'h0);
        checkOutput("A.holdData", 32'(ifA.data_out), 32'h2222);

        // Reset in IDLE, then again part-way through the clear.
        applyStimulusA(1'b0, 1'b1, 2'b11, 1'b0, 8'h05, 16'hBEEF);
        applyStimulusA(1'b0, 1'b0, 2'b00, 1'b1, 8'h05, 16'h0);
        applyStimulusA(1'b1, 1'b0, 2'b00, 1'b1, 8'h05, 16'h0);
        randomA(100, 15);
        applyStimulusA(1'b1, 1'b0, 2'b00, 1'b0, 8'h00, 16'h0);
        randomA(255, 15);
        checkOutput("A.readyLate", 32'(ifA.ready), 32'h0);
        randomA(1, 15);
        applyStimulusA(1'b0, 1'b0, 2'b00, 1'b1, 8'h05, 16'h0);
        checkOutput("A.clearedBeef", 32'(ifA.data_out), 32'h0);

        randomA(300, 15);
        randomA(300, 255);

        // 100x32 instance: non-power-of-two depth and out-of-range addresses.
        applyStimulusB(1'b1, 1'b0, 4'h0, 1'b0, 7'd0, 32'h0);
        applyStimulusB(1'b1, 1'b0, 4'h0, 1'b0, 7'd0, 32'h0);
        for (int n = 0; n < 100; n++) applyStimulusB(1'b0, 1'b0, 4'h0, 1'b0, 7'd0, 32'h0);
        checkOutput("B.readyAfterClear", 32'(ifB.ready), 32'h1);
        applyStimulusB(1'b0, 1'b1, 4'hF, 1'b0, 7'd100, 32'hDEADBEEF);
        applyStimulusB(1'b0, 1'b0, 4'h0, 1'b1, 7'd100, 32'h0);
        checkOutput("B.oorValid", 32'(ifB.data_valid), 32'h1);
        checkOutput("B.oorData", ifB.data_out, 32'h0);
        applyStimulusB(1'b0, 1'b1, 4'hF, 1'b0, 7'd99, 32'hCAFEF00D);
        applyStimulusB(1'b0, 1'b0, 4'h0, 1'b1, 7'd99, 32'h0);
        checkOutput("B.lastAddr", ifB.data_out, 32'hCAFEF00D);
        applyStimulusB(1'b0, 1'b0, 4'h0, 1'b1, 7'd0, 32'h0);
        checkOutput("B.aliasZero", ifB.data_out, 32'h0);
        randomB(400);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
